// File: rtl/driver_valvulas_pkg.sv
// rtl/driver_valvulas_pkg.sv - channel state encoding and default timing for the valve driver
package pkg_irrigacao;

    typedef enum logic [2:0] {
        FECHADO  = 3'd0,
        ABRINDO  = 3'd1,
        ABERTO   = 3'd2,
        FECHANDO = 3'd3,
        FALHA    = 3'd4
    } estado_t;

    localparam int W_PADRAO         = 8;
    localparam int T_MIN_ON_PADRAO  = 20;
    localparam int T_MIN_OFF_PADRAO = 20;
    localparam int T_CURSO_PADRAO   = 10;

endpackage

// File: rtl/driver_valvulas_canal_valvula.sv
// rtl/driver_valvulas_canal_valvula.sv - one valve channel: dwell-timed FSM with travel timeout
module canal_valvula
    import pkg_irrigacao::*;
#(
    parameter int W         = W_PADRAO,
    parameter int T_MIN_ON  = T_MIN_ON_PADRAO,
    parameter int T_MIN_OFF = T_MIN_OFF_PADRAO,
    parameter int T_CURSO   = T_CURSO_PADRAO
) (
    input  logic clk,
    input  logic rest,
    input  logic req,
    input  logic inhibit,
    input  logic permit,
    input  logic FB,
    output logic COIL,
    output logic aberto,
    output logic fechado,
    output logic falha,
    output logic pronto
);

    localparam logic [W-1:0] MIN_ON  = W'(T_MIN_ON);
    localparam logic [W-1:0] MIN_OFF = W'(T_MIN_OFF);
    localparam logic [W-1:0] CURSO   = W'(T_CURSO);

    estado_t      estado;
    logic [W-1:0] on_cnt;
    logic [W-1:0] off_cnt;
    logic [W-1:0] trav_cnt;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign fechado = (estado == FECHADO);
    assign falha   = (estado == FALHA);
    assign pronto  = fechado && (off_cnt >= MIN_OFF);

    // aberto is set only while the channel stays open across an edge, so the
    // pump rises one cycle after ABERTO is entered and falls on the leaving edge.
    always_ff @(posedge clk) begin
        if (rest) begin
            estado   <= FECHADO;
            COIL     <= 1'b0;
            aberto   <= 1'b0;
            on_cnt   <= '0;
            off_cnt  <= MIN_OFF;
            trav_cnt <= '0;
        end else begin
            case (estado)
                FECHADO: begin
                    off_cnt <= sat_inc(off_cnt);
                    if (req && !inhibit && permit && pronto) begin
                        estado   <= ABRINDO;
                        trav_cnt <= '0;
                        COIL     <= 1'b1;
                    end
                end
                ABRINDO: begin
                    trav_cnt <= sat_inc(trav_cnt);
                    if (inhibit) begin
                        estado   <= FECHANDO;
                        trav_cnt <= '0;
                        COIL     <= 1'b0;
                    end else if (FB) begin
                        estado <= ABERTO;
                        on_cnt <= '0;
                    end else if (trav_cnt >= CURSO) begin
                        estado <= FALHA;
                        COIL   <= 1'b0;
                    end
                end
                ABERTO: begin
                    on_cnt <= sat_inc(on_cnt);
                    if (inhibit || (!req && on_cnt >= MIN_ON)) begin
                        estado   <= FECHANDO;
                        trav_cnt <= '0;
                        COIL     <= 1'b0;
                        aberto   <= 1'b0;
                    end else begin
                        aberto <= 1'b1;
                    end
                end
                FECHANDO: begin
                    trav_cnt <= sat_inc(trav_cnt);
                    if (!FB) begin
                        estado  <= FECHADO;
                        off_cnt <= '0;
                    end else if (trav_cnt >= CURSO) begin
                        estado <= FALHA;
                    end
                end
                FALHA: begin
                    COIL   <= 1'b0;
                    aberto <= 1'b0;
                end
                default: begin
                    estado  <= FECHADO;
                    COIL    <= 1'b0;
                    aberto  <= 1'b0;
                    off_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/driver_valvulas.sv
// rtl/driver_valvulas.sv - valve/pump driver: three channels plus inhibit decode, interlock and pump
module driver_valvulas
    import pkg_irrigacao::*;
#(
    parameter int W         = W_PADRAO,
    parameter int T_MIN_ON  = T_MIN_ON_PADRAO,
    parameter int T_MIN_OFF = T_MIN_OFF_PADRAO,
    parameter int T_CURSO   = T_CURSO_PADRAO
) (
    input  logic       clk,
    input  logic       rest,
    input  logic       Vs,
    input  logic       Bs,
    input  logic       Ve,
    input  logic       Erro,
    input  logic       Vazio,
    input  logic       H,
    input  logic       FB_VS,
    input  logic       FB_BS,
    input  logic       FB_VE,
    output logic       COIL_VS,
    output logic       COIL_BS,
    output logic       COIL_VE,
    output logic       BOMBA,
    output logic [2:0] Falha
);

    logic inh_saida;
    logic inh_entrada;
    logic permit_vs;
    logic permit_bs;

    logic vs_aberto, vs_fechado, vs_falha, vs_pronto;
    logic bs_aberto, bs_fechado, bs_falha, bs_pronto;
    logic ve_aberto, ve_fechado, ve_falha, ve_pronto;
    logic sinais_unused;

    assign inh_saida   = Erro | Vazio;
    assign inh_entrada = Erro | H;

    // Sprinkler and drip share the pump line; on a simultaneous start the sprinkler wins.
    assign permit_vs = bs_fechado | bs_falha;
    assign permit_bs = (vs_fechado | vs_falha) && !(Vs && !inh_saida && vs_pronto);

    canal_valvula #(.W(W), .T_MIN_ON(T_MIN_ON), .T_MIN_OFF(T_MIN_OFF), .T_CURSO(T_CURSO)) u_vs (
        .clk     (clk),
        .rest    (rest),
        .req     (Vs),
        .inhibit (inh_saida),
        .permit  (permit_vs),
        .FB      (FB_VS),
        .COIL    (COIL_VS),
        .aberto  (vs_aberto),
        .fechado (vs_fechado),
        .falha   (vs_falha),
        .pronto  (vs_pronto)
    );

    canal_valvula #(.W(W), .T_MIN_ON(T_MIN_ON), .T_MIN_OFF(T_MIN_OFF), .T_CURSO(T_CURSO)) u_bs (
        .clk     (clk),
        .rest    (rest),
        .req     (Bs),
        .inhibit (inh_saida),
        .permit  (permit_bs),
        .FB      (FB_BS),
        .COIL    (COIL_BS),
        .aberto  (bs_aberto),
        .fechado (bs_fechado),
        .falha   (bs_falha),
        .pronto  (bs_pronto)
    );

    canal_valvula #(.W(W), .T_MIN_ON(T_MIN_ON), .T_MIN_OFF(T_MIN_OFF), .T_CURSO(T_CURSO)) u_ve (
        .clk     (clk),
        .rest    (rest),
        .req     (Ve),
        .inhibit (inh_entrada),
        .permit  (1'b1),
        .FB      (FB_VE),
        .COIL    (COIL_VE),
        .aberto  (ve_aberto),
        .fechado (ve_fechado),
        .falha   (ve_falha),
        .pronto  (ve_pronto)
    );

    // Both terms are flops and the interlock keeps them from being high together.
    assign BOMBA = vs_aberto | bs_aberto;
    assign Falha = {ve_falha, bs_falha, vs_falha};

    assign sinais_unused = &{1'b0, ve_aberto, ve_fechado, ve_pronto, bs_pronto};

endmodule

// File: tb/tb_driver_valvulas.sv
// tb/tb_driver_valvulas.sv - scoreboard bench for driver_valvulas with a valve plant and reference model
module tb_driver_valvulas;

    localparam int MIN_ON  = 20;
    localparam int MIN_OFF = 20;
    localparam int CURSO   = 10;

    typedef enum int {M_SHUT, M_RISING, M_OPEN, M_FALLING, M_STUCK} mph_t;

    typedef struct packed {
        logic [2:0] coil;
        logic       bomba;
        logic [2:0] falha;
    } exp_t;

    logic       clk = 1'b0;
    logic       rest, Vs, Bs, Ve, Erro, Vazio, H;
    logic       FB_VS, FB_BS, FB_VE;
    logic       COIL_VS, COIL_BS, COIL_VE, BOMBA;
    logic [2:0] Falha;

    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;

    mph_t        ph [3];
    int          age [3];
    logic [15:0] hist [3];
    int          lag [3];
    logic        stuck_en [3];
    logic        stuck_val [3];

    driver_valvulas dut (
        .clk     (clk),
        .rest    (rest),
        .Vs      (Vs),
        .Bs      (Bs),
        .Ve      (Ve),
        .Erro    (Erro),
        .Vazio   (Vazio),
        .H       (H),
        .FB_VS   (FB_VS),
        .FB_BS   (FB_BS),
        .FB_VE   (FB_VE),
        .COIL_VS (COIL_VS),
        .COIL_BS (COIL_BS),
        .COIL_VE (COIL_VE),
        .BOMBA   (BOMBA),
        .Falha   (Falha)
    );

    always #5 clk = ~clk;

    function automatic logic idle(input mph_t p);
        return (p == M_SHUT) || (p == M_STUCK);
    endfunction

    // Each channel is a phase plus "cycles spent in this phase"; all dwell rules read that one age.
    task automatic model_step();
        logic [2:0] req, inh, fbv, start, was_open;
        mph_t       nxt;
        exp_t       e;
        req = {Ve, Bs, Vs};
        inh = {Erro | H, Erro | Vazio, Erro | Vazio};
        fbv = {FB_VE, FB_BS, FB_VS};
        was_open = '0;
        if (rest) begin
            for (int c = 0; c < 3; c++) begin
                ph[c]   = M_SHUT;
                age[c]  = MIN_OFF;
                hist[c] = '0;
            end
        end else begin
            for (int c = 0; c < 3; c++)
                start[c] = (ph[c] == M_SHUT) && req[c] && !inh[c] && (age[c] >= MIN_OFF);
            start[0] = start[0] && idle(ph[1]);
            start[1] = start[1] && idle(ph[0]) && !start[0];
            for (int c = 0; c < 3; c++) begin
                was_open[c] = (ph[c] == M_OPEN);
                nxt = ph[c];
                case (ph[c])
                    M_SHUT:    if (start[c]) nxt = M_RISING;
                    M_RISING:  if (inh[c]) nxt = M_FALLING;
                               else if (fbv[c]) nxt = M_OPEN;
                               else if (age[c] >= CURSO) nxt = M_STUCK;
                    M_OPEN:    if (inh[c] || (!req[c] && age[c] >= MIN_ON)) nxt = M_FALLING;
                    M_FALLING: if (!fbv[c]) nxt = M_SHUT;
                               else if (age[c] >= CURSO) nxt = M_STUCK;
                    default:   nxt = M_STUCK;
                endcase
                if (nxt != ph[c]) begin
                    ph[c]  = nxt;
                    age[c] = 0;
                end else if (age[c] < 1000000) begin
                    age[c] = age[c] + 1;
                end
            end
        end
        for (int c = 0; c < 3; c++) begin
            e.coil[c]  = (ph[c] == M_RISING) || (ph[c] == M_OPEN);
            e.falha[c] = (ph[c] == M_STUCK);
            hist[c]    = {hist[c][14:0], e.coil[c]};
        end
        e.bomba = (ph[0] == M_OPEN && was_open[0]) || (ph[1] == M_OPEN && was_open[1]);
        sb.push_back(e);
    endtask

    // Plant: each valve's feedback follows the commanded coil after lag cycles, unless stuck.
    task automatic tick();
        logic [2:0] f;
        @(posedge clk);
        #1;
        model_step();
        for (int c = 0; c < 3; c++)
            f[c] = stuck_en[c] ? stuck_val[c] : hist[c][lag[c]];
        {FB_VE, FB_BS, FB_VS} = f;
    endtask

    task automatic cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic set_plant(input int l, input logic s_en, input logic s_val);
        for (int c = 0; c < 3; c++) begin
            lag[c]       = l;
            stuck_en[c]  = s_en;
            stuck_val[c] = s_val;
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({COIL_VE, COIL_BS, COIL_VS} !== e.coil) begin
                    errors++;
                    $display("FAIL coil t=%0t got %b expected %b", $time, {COIL_VE, COIL_BS, COIL_VS}, e.coil);
                end
                checks++;
                if (BOMBA !== e.bomba) begin
                    errors++;
                    $display("FAIL bomba t=%0t got %b expected %b", $time, BOMBA, e.bomba);
                end
                checks++;
                if (Falha !== e.falha) begin
                    errors++;
                    $display("FAIL falha t=%0t got %b expected %b", $time, Falha, e.falha);
                end
            end
        end
    end

    initial begin
        set_plant(0, 1'b1, 1'b1);
        {rest, Vs, Bs, Ve, Erro, Vazio, H} = '1;
        {FB_VS, FB_BS, FB_VE} = '1;
        hist[0] = '0; hist[1] = '0; hist[2] = '0;
        cyc(2);

        // Release into a sprinkler request; normal cycle and minimum-off reopen
        set_plant(3, 1'b0, 1'b0);
        {rest, Bs, Ve, Erro, Vazio, H} = '0;
        Vs = 1'b1;
        cyc(5);
        Vs = 1'b0;
        cyc(30);
        Vs = 1'b1;
        cyc(40);
        Vs = 1'b0;
        cyc(40);

        // Drip travel timeout, sticky until reset
        stuck_en[1] = 1'b1; stuck_val[1] = 1'b0;
        Bs = 1'b1;
        cyc(20);
        Bs = 1'b0;
        cyc(5);
        rest = 1'b1; cyc(2); rest = 1'b0;
        stuck_en[1] = 1'b0;

        // Erro while open, simultaneous request from idle, H while inlet open
        set_plant(2, 1'b0, 1'b0);
        Vs = 1'b1;
        cyc(8);
        Erro = 1'b1; cyc(1); Erro = 1'b0;
        Vs = 1'b0;
        cyc(30);
        Vs = 1'b1; Bs = 1'b1;
        cyc(10);
        Vs = 1'b0; Bs = 1'b0;
        Ve = 1'b1;
        cyc(8);
        H = 1'b1;
        cyc(5);
        {Ve, H} = '0;
        cyc(30);

        for (int s = 0; s < 20; s++) begin
            for (int c = 0; c < 3; c++) begin
                lag[c]       = ($urandom_range(0, 3) == 0) ? 12 : int'($urandom_range(0, 4));
                stuck_en[c]  = ($urandom_range(0, 15) == 0);
                stuck_val[c] = 1'($urandom_range(0, 1));
            end
            rest = 1'b1; cyc(2); rest = 1'b0;
            for (int k = 0; k < 200; k++) begin
                if ($urandom_range(0, 19) == 0) Vs = ~Vs;
                if ($urandom_range(0, 19) == 0) Bs = ~Bs;
                if ($urandom_range(0, 19) == 0) Ve = ~Ve;
                if ($urandom_range(0, 59) == 0) Vazio = ~Vazio;
                if ($urandom_range(0, 39) == 0) H = ~H;
                Erro = ($urandom_range(0, 79) == 0);
                tick();
            end
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
